// File: rtl/dp_ram_rx_auto_if.sv
// Avalon-MM register bus bundle for dp_ram_rx_auto.
// master drives read/write/address/writedata; slave returns readdata/waitrequest.
interface dp_ram_rx_auto_if;
    logic        read;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output read, write, address, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/dp_ram_rx_auto.sv
// Result-capture RAM: arith side writes results, HPS pops them over Avalon-MM
// through an auto-incrementing pointer and a prefetch holding register.
// Ports: avalon_clock, resetn, avs (Avalon slave), addr/data/we_arith, cap_en.
module dp_ram_rx_auto #(
    parameter int ID         = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  avalon_clock,
    input  logic                  resetn,
    dp_ram_rx_auto_if.slave       avs,
    input  logic [ADDR_WIDTH-1:0] addr_arith,
    input  logic [DATA_WIDTH-1:0] data_arith,
    input  logic                  we_arith,
    output logic                  cap_en
);
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    localparam logic [ADDR_WIDTH:0] WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] ram_dout;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  cap_en_q, cap_en_d;
    logic [ADDR_WIDTH:0]   wcount_q, wcount_d;
    logic [31:0]           readdata_q, readdata_d;

    logic arith_acc;
    logic wr_acc;
    logic rd_acc;
    logic pop;
    logic rd_addr_wr;
    logic wc_clr;

    // A write in the same cycle as a read wins; the read neither stalls nor completes.
    assign avs.waitrequest = avs.read && !avs.write &&
                             (avs.address == 3'd0) && (state_q != VALID);

    assign arith_acc  = we_arith && cap_en_q;
    assign wr_acc     = avs.write;
    assign rd_acc     = avs.read && !avs.write && !avs.waitrequest;
    assign pop        = rd_acc && (avs.address == 3'd0);
    assign rd_addr_wr = wr_acc && (avs.address == 3'd1);
    assign wc_clr     = wr_acc && (avs.address == 3'd4);

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        hold_d     = hold_q;
        cap_en_d   = cap_en_q;
        wcount_d   = wcount_q;
        readdata_d = readdata_q;

        unique case (state_q)
            FETCH:   state_d = LOAD;
            LOAD: begin
                hold_d  = ram_dout;
                state_d = VALID;
            end
            VALID:   state_d = VALID;
            default: state_d = FETCH;
        endcase

        if (rd_addr_wr)
            rd_ptr_d = avs.writedata[ADDR_WIDTH-1:0];
        if (wr_acc && (avs.address == 3'd2))
            cap_en_d = avs.writedata[0];

        if (rd_acc) begin
            unique case (avs.address)
                3'd0:    readdata_d = 32'(hold_q);
                3'd1:    readdata_d = 32'(rd_ptr_q);
                3'd2:    readdata_d = {31'b0, cap_en_q};
                3'd3:    readdata_d = 32'(ID);
                3'd4:    readdata_d = 32'(wcount_q);
                default: readdata_d = 32'd0;
            endcase
        end

        // Pointer wraps naturally at 2**ADDR_WIDTH.
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;

        // Any event that can make hold stale restarts the prefetch, including
        // a write landing mid-fetch.
        if (pop || rd_addr_wr || (arith_acc && (addr_arith == rd_ptr_q)))
            state_d = FETCH;

        if (wc_clr)
            wcount_d = '0;
        else if (arith_acc && (wcount_q != WC_MAX))
            wcount_d = wcount_q + 1'b1;
    end

    // RAM has no reset; contents survive resetn.
    always_ff @(posedge avalon_clock) begin
        if (arith_acc)
            ram[addr_arith] <= data_arith;
        ram_dout <= ram[rd_ptr_q];
    end

    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= FETCH;
            rd_ptr_q   <= '0;
            hold_q     <= '0;
            cap_en_q   <= 1'b0;
            wcount_q   <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            hold_q     <= hold_d;
            cap_en_q   <= cap_en_d;
            wcount_q   <= wcount_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign cap_en       = cap_en_q;
endmodule

// File: tb/tb_dp_ram_rx_auto.sv
// Directed bench for dp_ram_rx_auto: a default instance plus an ADDR_WIDTH=3
// instance sharing the same Avalon and arith stimulus.
module tb_dp_ram_rx_auto;
    logic        clk;
    logic        resetn;
    logic [10:0] addr_arith;
    logic [31:0] data_arith;
    logic        we_arith;
    logic        cap_en;
    logic        cap_en3;

    int n_cmp = 0;
    int n_err = 0;

    dp_ram_rx_auto_if bus ();
    dp_ram_rx_auto_if bus3 ();

    assign bus3.read      = bus.read;
    assign bus3.write     = bus.write;
    assign bus3.address   = bus.address;
    assign bus3.writedata = bus.writedata;

    dp_ram_rx_auto #(.ID(2), .DATA_WIDTH(32), .ADDR_WIDTH(11)) dut (
        .avalon_clock (clk),
        .resetn       (resetn),
        .avs          (bus),
        .addr_arith   (addr_arith),
        .data_arith   (data_arith),
        .we_arith     (we_arith),
        .cap_en       (cap_en)
    );

    dp_ram_rx_auto #(.ID(5), .DATA_WIDTH(32), .ADDR_WIDTH(3)) dut3 (
        .avalon_clock (clk),
        .resetn       (resetn),
        .avs          (bus3),
        .addr_arith   (addr_arith[2:0]),
        .data_arith   (data_arith),
        .we_arith     (we_arith),
        .cap_en       (cap_en3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge.
    task automatic av_write(input logic [2:0] a, input logic [31:0] d);
        bus.write     = 1'b1;
        bus.address   = a;
        bus.writedata = d;
        @(negedge clk);
        bus.write     = 1'b0;
    endtask

    task automatic av_read(input logic [2:0] a, output logic [31:0] d,
                           output logic [31:0] d3, output int stalls);
        stalls      = 0;
        bus.read    = 1'b1;
        bus.address = a;
        #1;
        while (bus.waitrequest && stalls < 20) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (bus.waitrequest)
            check("read_timeout", 32'(bus.waitrequest), 32'd0);
        @(negedge clk);
        bus.read = 1'b0;
        d  = bus.readdata;
        d3 = bus3.readdata;
    endtask

    task automatic arith_wr(input logic [10:0] a, input logic [31:0] d);
        we_arith   = 1'b1;
        addr_arith = a;
        data_arith = d;
        @(negedge clk);
        we_arith   = 1'b0;
    endtask

    logic [31:0] rd, rd3;
    int          st;

    initial begin
        resetn        = 1'b0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = 3'd0;
        bus.writedata = 32'd0;
        we_arith      = 1'b0;
        addr_arith    = 11'd0;
        data_arith    = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_readdata", bus.readdata, 32'd0);
        check("rst_cap_en", 32'(cap_en), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: capture four words, pop them back
        av_write(3'd2, 32'd1);
        check("t1_cap_en", 32'(cap_en), 32'd1);
        for (int i = 0; i < 4; i++)
            arith_wr(11'(i), 32'hA0 + 32'(i));
        av_write(3'd1, 32'd0);
        for (int i = 0; i < 4; i++) begin
            av_read(3'd0, rd, rd3, st);
            check($sformatf("t1_data%0d", i), rd, 32'hA0 + 32'(i));
            if (i > 0)
                check($sformatf("t1_stall%0d", i), 32'(st), 32'd2);
        end
        av_read(3'd4, rd, rd3, st);
        check("t1_wcount", rd, 32'd4);

        // 2: writes dropped while capture disabled
        arith_wr(11'd5, 32'h55);
        av_read(3'd4, rd, rd3, st);
        check("t2_wcount5", rd, 32'd5);
        av_write(3'd2, 32'd0);
        check("t2_cap_en", 32'(cap_en), 32'd0);
        arith_wr(11'd5, 32'hDEAD);
        av_write(3'd1, 32'd5);
        av_read(3'd0, rd, rd3, st);
        check("t2_data", rd, 32'h55);
        av_read(3'd4, rd, rd3, st);
        check("t2_wcount", rd, 32'd5);

        // 3: pointer wrap at top of RAM
        av_write(3'd2, 32'd1);
        arith_wr(11'd2047, 32'h77);
        arith_wr(11'd0, 32'h88);
        av_write(3'd1, 32'd2047);
        av_read(3'd0, rd, rd3, st);
        check("t3_data_top", rd, 32'h77);
        av_read(3'd0, rd, rd3, st);
        check("t3_data_wrap", rd, 32'h88);
        av_read(3'd1, rd, rd3, st);
        check("t3_rd_addr", rd, 32'd1);

        // 4: write to rd_ptr while VALID refreshes hold
        arith_wr(11'd7, 32'h11);
        av_write(3'd1, 32'd7);
        repeat (3) @(negedge clk);
        av_read(3'd1, rd, rd3, st);
        check("t4_rd_addr", rd, 32'd7);
        check("t4_no_stall", 32'(st), 32'd0);
        arith_wr(11'd7, 32'h22);
        av_read(3'd0, rd, rd3, st);
        check("t4_stall", 32'(st), 32'd2);
        check("t4_data", rd, 32'h22);

        // 5: wcount saturation (small instance) and clear priority
        av_write(3'd4, 32'h1234);
        av_read(3'd4, rd, rd3, st);
        check("t5_clr", rd, 32'd0);
        check("t5_clr3", rd3, 32'd0);
        for (int i = 0; i < 10; i++)
            arith_wr(11'(i), 32'(i));
        av_read(3'd4, rd, rd3, st);
        check("t5_wcount", rd, 32'd10);
        check("t5_wcount3_sat", rd3, 32'd8);
        av_write(3'd4, 32'hFFFF_FFFF);
        av_read(3'd4, rd, rd3, st);
        check("t5_clr3b", rd3, 32'd0);
        arith_wr(11'd12, 32'h5);
        arith_wr(11'd13, 32'h6);
        we_arith      = 1'b1;
        addr_arith    = 11'd14;
        data_arith    = 32'h7;
        bus.write     = 1'b1;
        bus.address   = 3'd4;
        bus.writedata = 32'd0;
        @(negedge clk);
        we_arith  = 1'b0;
        bus.write = 1'b0;
        av_read(3'd4, rd, rd3, st);
        check("t5_clr_wins", rd, 32'd0);
        check("t5_clr_wins3", rd3, 32'd0);

        // simultaneous read and write: write done, read ignored
        av_read(3'd3, rd, rd3, st);
        bus.read      = 1'b1;
        bus.write     = 1'b1;
        bus.address   = 3'd2;
        bus.writedata = 32'd0;
        #1;
        check("rw_no_wait", 32'(bus.waitrequest), 32'd0);
        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        check("rw_readdata", bus.readdata, 32'd2);
        check("rw_cap_en", 32'(cap_en), 32'd0);
        av_write(3'd2, 32'd1);

        // 6: reset during a stalled DATA read
        av_read(3'd3, rd, rd3, st);
        check("t6_id_pre", rd, 32'd2);
        av_write(3'd1, 32'd3);
        bus.read    = 1'b1;
        bus.address = 3'd0;
        #1;
        check("t6_stalled", 32'(bus.waitrequest), 32'd1);
        resetn = 1'b0;
        #1;
        check("t6_rst_readdata", bus.readdata, 32'd0);
        check("t6_rst_cap_en", 32'(cap_en), 32'd0);
        check("t6_rst_wait", 32'(bus.waitrequest), 32'd1);
        bus.read = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        av_read(3'd3, rd, rd3, st);
        check("t6_id", rd, 32'd2);
        check("t6_id3", rd3, 32'd5);
        av_read(3'd1, rd, rd3, st);
        check("t6_rd_ptr", rd, 32'd0);
        av_read(3'd4, rd, rd3, st);
        check("t6_wcount", rd, 32'd0);
        av_write(3'd1, 32'd2047);
        av_read(3'd0, rd, rd3, st);
        check("t6_ram_kept", rd, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
